// File: rtl/bytecode_fetch_pkg.sv
// Shared definitions for the bytecode fetch unit and the conversion state machine:
// FSM encoding, default memory geometry, opcode constants and the byte-lane helper.
package bytecode_fetch_pkg;

    localparam int DEFAULT_SIZE          = 256;
    localparam int DEFAULT_ADDRESS_WIDTH = 8;
    localparam logic [7:0] WIDE_OPCODE   = 8'hC4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } fetch_state_t;

    // JVM bytecode is big-endian: lane 0 is the most significant byte of the word.
    function automatic logic [7:0] get_byte_lane(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] result;
        case (lane)
            2'd0:    result = word[31:24];
            2'd1:    result = word[23:16];
            2'd2:    result = word[15:8];
            2'd3:    result = word[7:0];
            default: result = 8'h00;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/bytecode_fetch.sv
// Byte-serial fetch of JVM bytecode from a 32-bit word memory, with a one-word
// buffer so that consecutive bytes of the same word are served without a read.
module bytecode_fetch
    import bytecode_fetch_pkg::*;
#(
    parameter int SIZE          = DEFAULT_SIZE,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     pc_reset,
    output logic [7:0]               next_byte,
    output logic                     ready,
    output logic                     eof,
    output logic [ADDRESS_WIDTH+1:0] byte_pc,
    output logic                     mem_rd,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic [31:0]              mem_rdata
);

    // One extra bit lets the counter hold SIZE*4 itself, the end-of-code position.
    localparam int PCW = ADDRESS_WIDTH + 3;
    localparam logic [PCW-1:0] END_PC = PCW'(SIZE * 4);

    fetch_state_t             state_r;
    fetch_state_t             state_nxt_s;
    logic [PCW-1:0]           pc_r;
    logic [31:0]              buf_data_r;
    logic [ADDRESS_WIDTH-1:0] buf_tag_r;
    logic                     buf_valid_r;
    logic [7:0]               next_byte_r;
    logic [ADDRESS_WIDTH+1:0] byte_pc_r;
    logic                     ready_r;
    logic                     eof_r;
    logic                     mem_rd_r;
    logic [ADDRESS_WIDTH-1:0] mem_addr_r;

    logic [ADDRESS_WIDTH-1:0] word_idx_s;
    logic [1:0]               lane_s;
    logic                     hit_s;
    logic                     at_end_s;
    logic                     issue_rd_s;
    logic                     deliver_hit_s;
    logic                     deliver_mem_s;
    logic                     deliver_eof_s;

    // Next-state logic and the one-cycle action strobes for the datapath.
    always_comb begin
        word_idx_s    = pc_r[ADDRESS_WIDTH+1:2];
        lane_s        = pc_r[1:0];
        hit_s         = buf_valid_r && (buf_tag_r == word_idx_s);
        at_end_s      = (pc_r == END_PC);
        state_nxt_s   = state_r;
        issue_rd_s    = 1'b0;
        deliver_hit_s = 1'b0;
        deliver_mem_s = 1'b0;
        deliver_eof_s = 1'b0;
        if (pc_reset) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (at_end_s) begin
                            state_nxt_s   = ST_DELIVER;
                            deliver_eof_s = 1'b1;
                        end else if (hit_s) begin
                            state_nxt_s   = ST_DELIVER;
                            deliver_hit_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_REQ;
                            issue_rd_s  = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    state_nxt_s = ST_WAIT;
                end
                ST_WAIT: begin
                    state_nxt_s   = ST_DELIVER;
                    deliver_mem_s = 1'b1;
                end
                ST_DELIVER: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // PC, word buffer and registered outputs; delivery values are captured on entry to DELIVER.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r        <= '0;
            buf_data_r  <= 32'h0000_0000;
            buf_tag_r   <= '0;
            buf_valid_r <= 1'b0;
            next_byte_r <= 8'h00;
            byte_pc_r   <= '0;
            ready_r     <= 1'b0;
            eof_r       <= 1'b0;
            mem_rd_r    <= 1'b0;
            mem_addr_r  <= '0;
        end else begin
            ready_r  <= 1'b0;
            mem_rd_r <= 1'b0;
            if (pc_reset) begin
                pc_r        <= '0;
                buf_valid_r <= 1'b0;
            end else if (issue_rd_s) begin
                mem_rd_r   <= 1'b1;
                mem_addr_r <= word_idx_s;
            end else if (deliver_mem_s) begin
                buf_data_r  <= mem_rdata;
                buf_tag_r   <= word_idx_s;
                buf_valid_r <= 1'b1;
                next_byte_r <= get_byte_lane(mem_rdata, lane_s);
                byte_pc_r   <= pc_r[ADDRESS_WIDTH+1:0];
                ready_r     <= 1'b1;
                eof_r       <= 1'b0;
                pc_r        <= pc_r + PCW'(1);
            end else if (deliver_hit_s) begin
                next_byte_r <= get_byte_lane(buf_data_r, lane_s);
                byte_pc_r   <= pc_r[ADDRESS_WIDTH+1:0];
                ready_r     <= 1'b1;
                eof_r       <= 1'b0;
                pc_r        <= pc_r + PCW'(1);
            end else if (deliver_eof_s) begin
                next_byte_r <= 8'h00;
                byte_pc_r   <= pc_r[ADDRESS_WIDTH+1:0];
                ready_r     <= 1'b1;
                eof_r       <= 1'b1;
            end
        end
    end

    assign next_byte = next_byte_r;
    assign byte_pc   = byte_pc_r;
    assign ready     = ready_r;
    assign eof       = eof_r;
    assign mem_rd    = mem_rd_r;
    assign mem_addr  = mem_addr_r;

endmodule

// File: tb/tb_bytecode_fetch.sv
// Directed bench for bytecode_fetch: stimulus pushes expected deliveries into a
// scoreboard queue, an independent monitor pops and compares on every ready pulse.
module tb_bytecode_fetch;

    localparam int SIZE = 2;
    localparam int AW   = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          pc_reset = 1'b0;
    logic [7:0]    next_byte;
    logic          ready;
    logic          eof;
    logic [AW+1:0] byte_pc;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata = 32'h0;

    logic [31:0] mem [SIZE];

    typedef struct {
        logic [7:0]    exp_byte;
        logic [AW+1:0] exp_pc;
        logic          exp_eof;
        logic          chk_pc;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    bytecode_fetch #(.SIZE(SIZE), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .pc_reset(pc_reset),
        .next_byte(next_byte), .ready(ready), .eof(eof), .byte_pc(byte_pc),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Word memory: data valid exactly one cycle after mem_rd, garbage otherwise.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        else        mem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ready: got ready with byte %0h pc %0h, expected none", next_byte, byte_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("next_byte", {24'h0, next_byte}, {24'h0, e.exp_byte});
                check("eof", {31'h0, eof}, {31'h0, e.exp_eof});
                if (e.chk_pc) check("byte_pc", {{(32-AW-2){1'b0}}, byte_pc}, {{(32-AW-2){1'b0}}, e.exp_pc});
            end
        end
    end

    // mode: 0 plain start, 1 extra start in N+1, 2 pc_reset in N+1,
    //       3 pc_reset together with start, 4 reset in N+2
    task automatic run(input string name, input int mode, input int exp_lat, input int exp_rd,
                       input logic [AW-1:0] exp_addr, input logic [7:0] eb,
                       input logic [AW+1:0] epc, input logic ee, input logic chk_pc);
        int lat;
        int rd;
        exp_t e;
        if (exp_lat != 0) begin
            e.exp_byte = eb; e.exp_pc = epc; e.exp_eof = ee; e.chk_pc = chk_pc;
            sb.push_back(e);
        end
        lat = 0;
        rd  = 0;
        @(negedge clk);
        start    = 1'b1;
        pc_reset = (mode == 3);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (ready && lat == 0) lat = k;
            if (mem_rd) begin
                rd++;
                check({name, "_mem_addr"}, {{(32-AW){1'b0}}, mem_addr}, {{(32-AW){1'b0}}, exp_addr});
            end
            if (mode == 4 && k == 3) begin
                check({name, "_rst_byte"}, {24'h0, next_byte}, 32'h0);
                check({name, "_rst_pc"}, {{(32-AW-2){1'b0}}, byte_pc}, 32'h0);
                check({name, "_rst_flags"}, {29'h0, ready, eof, mem_rd}, 32'h0);
                check({name, "_rst_addr"}, {{(32-AW){1'b0}}, mem_addr}, 32'h0);
            end
            start    = (mode == 1 && k == 1);
            pc_reset = (mode == 2 && k == 1);
            reset    = (mode == 4 && k == 2);
        end
        start    = 1'b0;
        pc_reset = 1'b0;
        reset    = 1'b0;
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_mem_rd_count"}, rd, exp_rd);
    endtask

    task automatic pulse_pc_reset();
        @(negedge clk);
        pc_reset = 1'b1;
        @(negedge clk);
        pc_reset = 1'b0;
    endtask

    initial begin
        mem[0] = 32'h1A2B_3C4D;
        mem[1] = 32'hC415_0007;
        repeat (3) @(negedge clk);
        check("reset_outputs", {21'h0, next_byte, ready, eof, mem_rd}, 32'h0);
        check("reset_byte_pc", {{(32-AW-2){1'b0}}, byte_pc}, 32'h0);
        reset = 1'b0;

        // Word 0: one miss then three hits.
        run("w0_b0", 0, 3, 1, 1'b0, 8'h1A, 3'd0, 1'b0, 1'b1);
        run("w0_b1", 0, 1, 0, 1'b0, 8'h2B, 3'd1, 1'b0, 1'b1);
        run("w0_b2", 0, 1, 0, 1'b0, 8'h3C, 3'd2, 1'b0, 1'b1);
        run("w0_b3", 0, 1, 0, 1'b0, 8'h4D, 3'd3, 1'b0, 1'b1);
        // Lane 3 -> next word misses; a start while busy is dropped.
        run("w1_b0", 1, 3, 1, 1'b1, 8'hC4, 3'd4, 1'b0, 1'b1);
        run("w1_b1", 0, 1, 0, 1'b1, 8'h15, 3'd5, 1'b0, 1'b1);
        run("w1_b2", 0, 1, 0, 1'b1, 8'h00, 3'd6, 1'b0, 1'b1);
        run("w1_b3", 0, 1, 0, 1'b1, 8'h07, 3'd7, 1'b0, 1'b1);
        // End of code: eof with zero byte, no read, repeatable.
        run("eof_a", 0, 1, 0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        run("eof_b", 0, 1, 0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);

        // pc_reset aborts an in-flight miss; next start re-reads word 0.
        pulse_pc_reset();
        run("abort_req", 2, 0, 1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        run("reread", 0, 3, 1, 1'b0, 8'h1A, 3'd0, 1'b0, 1'b1);

        // Advance to PC=5, then start and pc_reset together.
        run("adv_b1", 0, 1, 0, 1'b0, 8'h2B, 3'd1, 1'b0, 1'b1);
        run("adv_b2", 0, 1, 0, 1'b0, 8'h3C, 3'd2, 1'b0, 1'b1);
        run("adv_b3", 0, 1, 0, 1'b0, 8'h4D, 3'd3, 1'b0, 1'b1);
        run("adv_b4", 0, 3, 1, 1'b1, 8'hC4, 3'd4, 1'b0, 1'b1);
        run("start_pcrst", 3, 0, 0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        run("after_pcrst", 0, 3, 1, 1'b0, 8'h1A, 3'd0, 1'b0, 1'b1);

        // Reset while waiting for memory data.
        pulse_pc_reset();
        run("rst_wait", 4, 0, 1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        run("after_rst", 0, 3, 1, 1'b0, 8'h1A, 3'd0, 1'b0, 1'b1);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
